ethernet_tx_scheduler: RTL and testbench
========================================

// Module: ethernet_tx_scheduler
//
// PURPOSE
//   Sequences and shares the single ethernet_tx frame transmitter between two requesters:
//   - bus read responses, buffered in a FIFO;
//   - an event channel that uses a req/ack handshake.
//   Issues one valid_i pulse per frame and tracks the frame on txen. Enforces an inter-frame
//   gap before the next launch. Sits between the bus/event logic and ethernet_tx.
//
// PARAMETERS
//   DEPTH          8    response FIFO entries (power of two, >=2)
//   IFG_CYCLES     48   idle clk cycles after txen falls before the next launch (>=1)
//   START_TIMEOUT  64   max cycles from launch to txen rising before the frame is abandoned
//   HB_PERIOD      1e6  heartbeat idle period (used only with the heartbeat macro)
//   HB_WORD        16'hBEEF  heartbeat payload
//
// PORTS
//   clk           in   1   system clock
//   rst           in   1   synchronous reset, active high
//   resp_data_i   in   16  bus read data to return to the host
//   resp_rw_i     in   1   bus op type; 0 = read (only reads generate frames)
//   resp_valid_i  in   1   bus op complete, single-cycle strobe
//   evt_data_i    in   16  event payload
//   evt_req_i     in   1   event request level; held until acked
//   evt_ack_o     out  1   1-cycle pulse when the event is granted
//   etx_rdata_o   out  16  to ethernet_tx rdata_i
//   etx_rw_o      out  1   to ethernet_tx rw_i; always 0
//   etx_valid_o   out  1   to ethernet_tx valid_i; 1-cycle launch pulse
//   etx_txen_i    in   1   ethernet_tx txen, monitored
//   fifo_count_o  out  $clog2(DEPTH+1)  entries held in the FIFO
//   busy_o        out  1   state != IDLE
//   overflow_o    out  1   sticky: a response was dropped because the FIFO was full
//   timeout_o     out  1   sticky: txen did not rise within START_TIMEOUT
//
// BEHAVIOUR
//   Reset:
//   - All outputs are 0; FIFO empty; state IDLE; counters 0.
//   - last_grant = EVT, so a response wins the first tie.
//   FIFO:
//   - Push when resp_valid_i && !resp_rw_i.
//   - Push while full (count==DEPTH) is dropped and sets overflow_o, even if a pop occurs the same cycle.
//   - Pointers wrap mod DEPTH.
//   FSM:
//   - IDLE:
//     - Wait for etx_txen_i==0 and a pending source (FIFO non-empty or evt_req_i).
//     - If both are pending, grant the source opposite last_grant (round-robin).
//     - Latch the payload. A response pops the FIFO; an event pulses evt_ack_o in this cycle.
//     - Go to LAUNCH.
//   - LAUNCH: etx_valid_o=1 for exactly this cycle, etx_rdata_o = latched word; go to WAIT_START.
//   - WAIT_START:
//     - On etx_txen_i==1, go to WAIT_END.
//     - If START_TIMEOUT cycles elapse without it, set timeout_o and go to GAP. The word is lost.
//   - WAIT_END: on etx_txen_i==0, go to GAP.
//   - GAP: count IFG_CYCLES cycles, then go to IDLE.
//   Latency: a push into an empty FIFO at cycle N becomes visible at N+1; etx_valid_o rises at N+2.
//   Output holds:
//   - etx_rdata_o holds the latched word from LAUNCH until the next grant.
//   - etx_rw_o is constant 0.
//   Simultaneous events:
//   - A push and a pop in the same cycle leave the count unchanged.
//   - evt_req_i dropped before the grant: no ack, no frame.
//   Reset mid-frame:
//   - The scheduler returns to IDLE, but ethernet_tx keeps sending.
//   - IDLE's txen==0 guard blocks any new launch until that frame ends.
//   - No IFG is enforced after reset.
//
// CONFIGURATION
//   ETHERNET_TX_SCHED_HEARTBEAT_EN defined:
//   - A counter increments while state==IDLE with no pending source, and clears on any grant.
//   - When it reaches HB_PERIOD-1, a heartbeat frame with payload HB_WORD is launched.
//   - The heartbeat is the lowest priority and does not update last_grant.
//   Not defined: no heartbeat logic; HB_PERIOD and HB_WORD are unused.
//
// TESTING (txen model: rises 3 cycles after valid, held 400 cycles; IFG_CYCLES=48)
//   1. Single read, resp_data_i=16'h6970 -> one etx_valid_o pulse 2 cycles later,
//      rdata=16'h6970, rw=0, busy_o until the gap ends.
//   2. Write strobe (resp_rw_i=1) -> no frame; fifo_count_o stays 0.
//   3. Back-to-back: 3 reads, then evt_req_i with 16'h1234 ->
//      order resp, evt, resp, resp; evt_ack_o pulses once;
//      launch-to-launch >= 400+48 cycles.
//   4. 10 reads in 10 cycles with DEPTH=8 -> 1 sent, 8 queued, 1 dropped; overflow_o=1;
//      the remaining 8 go out in order.
//   5. txen held 0 after launch -> timeout_o=1 at cycle 64; after the gap the next FIFO word launches.
//   6. rst asserted while txen=1 and 2 words queued -> FIFO empty, outputs 0;
//      no launch until txen falls.
//      With ETHERNET_TX_SCHED_HEARTBEAT_EN and HB_PERIOD=100: idle -> 16'hBEEF frame every ~100 cycles plus frame time.

Source files
------------

// File: rtl/ethernet_tx_scheduler.sv
// rtl/ethernet_tx_scheduler.sv - shares one ethernet_tx between a response FIFO and an event req/ack channel
// Optional heartbeat frames: define ETHERNET_TX_SCHED_HEARTBEAT_EN.
module ethernet_tx_scheduler #(
  parameter int          DEPTH         = 8,
  parameter int          IFG_CYCLES    = 48,
  parameter int          START_TIMEOUT = 64,
  parameter int          HB_PERIOD     = 1000000,
  parameter logic [15:0] HB_WORD       = 16'hBEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  resp_data_i,
  input  logic                         resp_rw_i,
  input  logic                         resp_valid_i,
  input  logic [15:0]                  evt_data_i,
  input  logic                         evt_req_i,
  output logic                         evt_ack_o,
  output logic [15:0]                  etx_rdata_o,
  output logic                         etx_rw_o,
  output logic                         etx_valid_o,
  input  logic                         etx_txen_i,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o,
  output logic                         busy_o,
  output logic                         overflow_o,
  output logic                         timeout_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int CNT_MAX = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);

  localparam logic GRANT_RESP = 1'b0;
  localparam logic GRANT_EVT  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_END,
    S_GAP
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       rdata_q;
  logic              valid_q;
  logic              last_grant_q;
  logic              timeout_q;
  logic              overflow_q;

  logic [15:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;

  logic push_req;
  logic full;
  logic push_ok;
  logic pop;
  logic pending_resp;
  logic pending_evt;
  logic can_grant;
  logic grant_resp;
  logic grant_evt;
  logic grant_hb;
  logic any_grant;

  assign push_req     = resp_valid_i & ~resp_rw_i;
  assign full         = (count_q == FULL_CNT);
  assign push_ok      = push_req & ~full;
  assign pending_resp = (count_q != '0);
  assign pending_evt  = evt_req_i;
  assign can_grant    = (state_q == S_IDLE) && !etx_txen_i;
  assign pop          = grant_resp;
  assign any_grant    = grant_resp | grant_evt | grant_hb;

  // Round-robin only matters on a tie; otherwise whichever source is pending wins.
  always_comb begin
    grant_resp = 1'b0;
    grant_evt  = 1'b0;
    if (can_grant) begin
      if (pending_resp && pending_evt) begin
        if (last_grant_q == GRANT_EVT) grant_resp = 1'b1;
        else                           grant_evt  = 1'b1;
      end else if (pending_resp) begin
        grant_resp = 1'b1;
      end else if (pending_evt) begin
        grant_evt = 1'b1;
      end
    end
  end

`ifdef ETHERNET_TX_SCHED_HEARTBEAT_EN
  localparam logic [31:0] HB_LAST = 32'(HB_PERIOD - 1);
  logic [31:0] hb_cnt_q;

  assign grant_hb = can_grant && !pending_resp && !pending_evt && (hb_cnt_q == HB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt_q <= '0;
    end else if (any_grant) begin
      hb_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && !pending_resp && !pending_evt && (hb_cnt_q != HB_LAST)) begin
      hb_cnt_q <= hb_cnt_q + 32'd1;
    end
  end
`else
  logic [15:0] unused_hb;
  assign grant_hb  = 1'b0;
  assign unused_hb = HB_WORD ^ HB_PERIOD[15:0];
`endif

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= resp_data_i;
  end

  // A push into a full FIFO is dropped even when a pop frees a slot that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_req && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      valid_q      <= 1'b0;
      last_grant_q <= GRANT_EVT;
      timeout_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (grant_resp) begin
            rdata_q      <= mem_q[rd_ptr_q];
            last_grant_q <= GRANT_RESP;
            valid_q      <= 1'b1;
            state_q      <= S_LAUNCH;
          end else if (grant_evt) begin
            rdata_q      <= evt_data_i;
            last_grant_q <= GRANT_EVT;
            valid_q      <= 1'b1;
            state_q      <= S_LAUNCH;
          end
`ifdef ETHERNET_TX_SCHED_HEARTBEAT_EN
          else if (grant_hb) begin
            rdata_q <= HB_WORD;
            valid_q <= 1'b1;
            state_q <= S_LAUNCH;
          end
`endif
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (etx_txen_i) begin
            cnt_q   <= '0;
            state_q <= S_WAIT_END;
          end else if (cnt_q == TO_LAST) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= S_GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_END: begin
          cnt_q <= '0;
          if (!etx_txen_i) state_q <= S_GAP;
        end
        S_GAP: begin
          if (cnt_q == IFG_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_ack_o    = grant_evt;
  assign etx_rdata_o  = rdata_q;
  assign etx_rw_o     = 1'b0;
  assign etx_valid_o  = valid_q;
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != S_IDLE);
  assign overflow_o   = overflow_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_ethernet_tx_scheduler.sv
// tb/tb_ethernet_tx_scheduler.sv - directed bench for ethernet_tx_scheduler with a txen responder model
module tb_ethernet_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] resp_data;
  logic        resp_rw;
  logic        resp_valid;
  logic [15:0] evt_data;
  logic        evt_req;
  logic        evt_ack;
  logic [15:0] etx_rdata;
  logic        etx_rw;
  logic        etx_valid;
  logic        etx_txen;
  logic [3:0]  fifo_count;
  logic        busy;
  logic        overflow;
  logic        timeout;

  int          checks = 0;
  int          errors = 0;
  bit          model_en = 1'b1;
  int          ack_cnt = 0;
  int          cyc = 0;
  logic [15:0] log_data [$];
  int          log_cyc [$];

  always #5 clk = ~clk;

  ethernet_tx_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .resp_data_i  (resp_data),
    .resp_rw_i    (resp_rw),
    .resp_valid_i (resp_valid),
    .evt_data_i   (evt_data),
    .evt_req_i    (evt_req),
    .evt_ack_o    (evt_ack),
    .etx_rdata_o  (etx_rdata),
    .etx_rw_o     (etx_rw),
    .etx_valid_o  (etx_valid),
    .etx_txen_i   (etx_txen),
    .fifo_count_o (fifo_count),
    .busy_o       (busy),
    .overflow_o   (overflow),
    .timeout_o    (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_launches(input int n, input int bound);
    int k = 0;
    while (log_data.size() < n && k < bound) begin
      step();
      k++;
    end
    check("launch_count", log_data.size(), n);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin
      step();
      k++;
    end
    check("idle_reached", busy, 0);
  endtask

  // ethernet_tx stand-in: txen rises 3 cycles after the launch pulse and stays up 400 cycles.
  initial begin
    etx_txen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (model_en && etx_valid) begin
        repeat (3) @(posedge clk);
        #1 etx_txen = 1'b1;
        repeat (400) @(posedge clk);
        #1 etx_txen = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      cyc++;
      if (etx_valid) begin
        log_data.push_back(etx_rdata);
        log_cyc.push_back(cyc);
      end
      if (evt_ack) ack_cnt++;
    end
  end

  initial begin
    int  base;
    int  k;
    bit  got;
    bit  saw;

    rst        = 1'b1;
    resp_data  = '0;
    resp_rw    = 1'b0;
    resp_valid = 1'b0;
    evt_data   = '0;
    evt_req    = 1'b0;
    repeat (3) step();
    check("rst_valid",    etx_valid, 0);
    check("rst_rdata",    etx_rdata, 0);
    check("rst_rw",       etx_rw, 0);
    check("rst_busy",     busy, 0);
    check("rst_count",    fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout",  timeout, 0);
    check("rst_ack",      evt_ack, 0);
    rst = 1'b0;
    step();

    // single read: visible next cycle, launched the cycle after
    resp_data  = 16'h6970;
    resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    check("t1_count_n1", fifo_count, 1);
    check("t1_valid_n1", etx_valid, 0);
    step();
    check("t1_valid_n2", etx_valid, 1);
    check("t1_rdata",    etx_rdata, 16'h6970);
    check("t1_rw",       etx_rw, 0);
    check("t1_busy",     busy, 1);
    check("t1_count_n2", fifo_count, 0);
    step();
    check("t1_valid_pulse", etx_valid, 0);
    wait_idle(600);
    check("t1_rdata_hold", etx_rdata, 16'h6970);
    check("t1_frames", log_data.size(), 1);

    // write strobe makes no frame
    resp_data  = 16'hFFFF;
    resp_rw    = 1'b1;
    resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    resp_rw    = 1'b0;
    check("t2_count", fifo_count, 0);
    repeat (5) step();
    check("t2_busy",   busy, 0);
    check("t2_frames", log_data.size(), 1);

    // three reads then an event: resp, evt, resp, resp
    base = log_data.size();
    for (int i = 0; i < 3; i++) begin
      resp_data  = 16'hA001 + 16'(i);
      resp_valid = 1'b1;
      step();
    end
    resp_valid = 1'b0;
    evt_data   = 16'h1234;
    evt_req    = 1'b1;
    got = 1'b0;
    k   = 0;
    while (!got && k < 2000) begin
      step();
      k++;
      if (evt_ack) got = 1'b1;
    end
    check("t3_ack_seen", got, 1);
    step();
    evt_req = 1'b0;
    wait_launches(base + 4, 3000);
    check("t3_order0", log_data[base],     16'hA001);
    check("t3_order1", log_data[base + 1], 16'h1234);
    check("t3_order2", log_data[base + 2], 16'hA002);
    check("t3_order3", log_data[base + 3], 16'hA003);
    check("t3_ack_cnt", ack_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      check("t3_spacing", (log_cyc[base + i + 1] - log_cyc[base + i]) >= 448, 1);
    end
    wait_idle(600);

    // ten reads into an 8-deep FIFO: one sent, eight queued, one dropped
    base = log_data.size();
    for (int i = 0; i < 10; i++) begin
      resp_data  = 16'hB000 + 16'(i);
      resp_valid = 1'b1;
      step();
    end
    resp_valid = 1'b0;
    check("t4_count_full", fifo_count, 8);
    check("t4_overflow",   overflow, 1);
    wait_launches(base + 9, 6000);
    for (int i = 0; i < 9; i++) begin
      check("t4_order", log_data[base + i], 16'hB000 + 16'(i));
    end
    wait_idle(600);
    repeat (10) step();
    check("t4_no_extra", log_data.size(), base + 9);

    // txen never rises: timeout after 64 WAIT_START cycles, then gap, then next word
    model_en   = 1'b0;
    resp_data  = 16'hC5C5;
    resp_valid = 1'b1;
    step();
    resp_data  = 16'hC6C6;
    step();
    resp_valid = 1'b0;
    k = 0;
    while (!etx_valid && k < 20) begin
      step();
      k++;
    end
    check("t5_first_launch", etx_valid, 1);
    check("t5_first_rdata",  etx_rdata, 16'hC5C5);
    model_en = 1'b1;
    repeat (64) step();
    check("t5_timeout_before", timeout, 0);
    step();
    check("t5_timeout_set", timeout, 1);
    check("t5_busy_gap",    busy, 1);
    k = 0;
    while (!etx_valid && k < 200) begin
      step();
      k++;
    end
    check("t5_relaunch_delay", k, 49);
    check("t5_second_rdata",   etx_rdata, 16'hC6C6);
    wait_idle(600);

    // reset mid-frame: FIFO cleared, no launch until txen falls, no gap afterwards
    for (int i = 0; i < 3; i++) begin
      resp_data  = 16'hD001 + 16'(i);
      resp_valid = 1'b1;
      step();
    end
    resp_valid = 1'b0;
    k = 0;
    while (!etx_txen && k < 50) begin
      step();
      k++;
    end
    check("t6_count_pre", fifo_count, 2);
    rst = 1'b1;
    step();
    step();
    check("t6_count",    fifo_count, 0);
    check("t6_busy",     busy, 0);
    check("t6_valid",    etx_valid, 0);
    check("t6_rdata",    etx_rdata, 0);
    check("t6_overflow", overflow, 0);
    check("t6_timeout",  timeout, 0);
    rst = 1'b0;
    base       = log_data.size();
    resp_data  = 16'hE001;
    resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    saw = 1'b0;
    k   = 0;
    while (etx_txen && k < 500) begin
      if (etx_valid) saw = 1'b1;
      step();
      k++;
    end
    check("t6_no_launch_txen", saw, 0);
    check("t6_frames_held",    log_data.size(), base);
    step();
    check("t6_launch_after", etx_valid, 1);
    check("t6_launch_rdata", etx_rdata, 16'hE001);
    wait_idle(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
